// File: rtl/sd_bd_fifo.sv
// sd_bd_fifo - buffer-descriptor store between the Wishbone register block and
// the DMA/data-master side. Each descriptor is a 32-bit system address followed
// by a 32-bit card block address, split into WPB words of MEM_WIDTH bits.
// One instance serves RX and one serves TX.
//
// Ports
//   wb_clk_i    system clock, rising edge
//   wb_rst_n_i  asynchronous active-low reset
//   clr_i       synchronous flush, wins over every other input
//   we_m        master write strobe, one word per cycle
//   dat_in_m    master write data
//   free_bd     empty descriptor slots (partially written slot counts as free)
//   overflow_o  one-cycle pulse when a write was dropped because the store is full
//   re_s        slave read request, one word per pulse
//   ack_o_s     read data valid, one cycle after an accepted re_s
//   dat_out_s   read data, held until the next ack
//   bd_avail    at least one committed descriptor not yet started by the reader
//   a_cmp       reader finished its current descriptor, release the slot
module sd_bd_fifo #(
  parameter int MEM_WIDTH = 16,
  parameter int BD_SIZE   = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 clr_i,
  input  logic                 we_m,
  input  logic [MEM_WIDTH-1:0] dat_in_m,
  output logic [7:0]           free_bd,
  output logic                 overflow_o,
  input  logic                 re_s,
  output logic                 ack_o_s,
  output logic [MEM_WIDTH-1:0] dat_out_s,
  output logic                 bd_avail,
  input  logic                 a_cmp
);

  localparam int WPB   = 64 / MEM_WIDTH;
  localparam int DEPTH = BD_SIZE * WPB;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(WPB);

  logic [MEM_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] wcnt, rcnt;
  logic [7:0]    ready_cnt, outstanding;

  logic          wr_ok, wr_last;
  logic          rel_out, rel_abn, rel_any;
  logic          rd_ok, rd_first, rd_last;
  logic [7:0]    ready_cnt_nxt;

  always_comb begin
    wr_ok    = we_m && (free_bd != 8'd0);
    wr_last  = wr_ok && (wcnt == CW'(WPB - 1));
    // A release first retires a fully read descriptor; with none outstanding
    // it abandons the descriptor the reader is part-way through.
    rel_out  = a_cmp && (outstanding != 8'd0);
    rel_abn  = a_cmp && (outstanding == 8'd0) && (rcnt != '0);
    rel_any  = rel_out || rel_abn;
    // An abandon realigns rptr this cycle, so a coincident read is not taken.
    rd_ok    = re_s && !rel_abn && ((rcnt != '0) || (ready_cnt != 8'd0));
    rd_first = rd_ok && (rcnt == '0);
    rd_last  = rd_ok && (rcnt == CW'(WPB - 1));
    ready_cnt_nxt = ready_cnt + 8'(wr_last) - 8'(rd_first);
  end

  // Storage has no reset; contents are don't-care after reset/flush.
  always_ff @(posedge wb_clk_i) begin
    if (wr_ok && !clr_i)
      mem[wptr] <= dat_in_m;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wptr        <= '0;
      rptr        <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      ready_cnt   <= '0;
      outstanding <= '0;
      free_bd     <= 8'(BD_SIZE);
      overflow_o  <= 1'b0;
      ack_o_s     <= 1'b0;
      dat_out_s   <= '0;
      bd_avail    <= 1'b0;
    end else if (clr_i) begin
      wptr        <= '0;
      rptr        <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      ready_cnt   <= '0;
      outstanding <= '0;
      free_bd     <= 8'(BD_SIZE);
      overflow_o  <= 1'b0;
      ack_o_s     <= 1'b0;
      dat_out_s   <= '0;
      bd_avail    <= 1'b0;
    end else begin
      overflow_o <= we_m && !wr_ok;
      ack_o_s    <= rd_ok;

      if (wr_ok) begin
        wptr <= wptr + AW'(1);
        wcnt <= wcnt + CW'(1);
      end

      if (rel_abn) begin
        rptr <= rptr + AW'(WPB) - AW'(rcnt);
        rcnt <= '0;
      end else if (rd_ok) begin
        dat_out_s <= mem[rptr];
        rptr      <= rptr + AW'(1);
        rcnt      <= rcnt + CW'(1);
      end

      ready_cnt   <= ready_cnt_nxt;
      bd_avail    <= (ready_cnt_nxt != 8'd0);
      outstanding <= outstanding + 8'(rd_last) - 8'(rel_out);

      // Commit and release in the same cycle cancel out.
      if (wr_last && !rel_any)
        free_bd <= free_bd - 8'd1;
      else if (rel_any && !wr_last)
        free_bd <= free_bd + 8'd1;
    end
  end

endmodule

// File: tb/tb_sd_bd_fifo.sv
// Directed bench for sd_bd_fifo (MEM_WIDTH=16, BD_SIZE=8, four words per descriptor).
module tb_sd_bd_fifo;

  logic        clk;
  logic        rst_n;
  logic        clr_i;
  logic        we_m;
  logic [15:0] dat_in_m;
  logic [7:0]  free_bd;
  logic        overflow_o;
  logic        re_s;
  logic        ack_o_s;
  logic [15:0] dat_out_s;
  logic        bd_avail;
  logic        a_cmp;

  int n_chk  = 0;
  int n_pass = 0;

  sd_bd_fifo #(.MEM_WIDTH(16), .BD_SIZE(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .clr_i      (clr_i),
    .we_m       (we_m),
    .dat_in_m   (dat_in_m),
    .free_bd    (free_bd),
    .overflow_o (overflow_o),
    .re_s       (re_s),
    .ack_o_s    (ack_o_s),
    .dat_out_s  (dat_out_s),
    .bd_avail   (bd_avail),
    .a_cmp      (a_cmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] w);
    we_m = 1'b1;
    dat_in_m = w;
    tick();
    we_m = 1'b0;
  endtask

  task automatic wr_desc(input logic [15:0] base);
    for (int i = 0; i < 4; i++) wr(base + 16'(i));
  endtask

  task automatic rd(input string tag, input logic [15:0] exp);
    re_s = 1'b1;
    tick();
    re_s = 1'b0;
    chk({tag, "_ack"}, 32'(ack_o_s), 32'd1);
    chk({tag, "_dat"}, 32'(dat_out_s), 32'(exp));
  endtask

  task automatic rd_desc(input string tag, input logic [15:0] base);
    for (int i = 0; i < 4; i++) rd(tag, base + 16'(i));
  endtask

  task automatic cmp();
    a_cmp = 1'b1;
    tick();
    a_cmp = 1'b0;
  endtask

  initial begin
    int fr;
    rst_n = 1'b0; clr_i = 1'b0; we_m = 1'b0; dat_in_m = '0; re_s = 1'b0; a_cmp = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_free", 32'(free_bd), 32'd8);
    chk("rst_avail", 32'(bd_avail), 32'd0);
    chk("rst_ack", 32'(ack_o_s), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_dat", 32'(dat_out_s), 32'd0);

    // T1: reset in the middle of a descriptor write
    wr(16'hAAAA); wr(16'hBBBB);
    rst_n = 1'b0;
    #1;
    chk("t1_free", 32'(free_bd), 32'd8);
    chk("t1_avail", 32'(bd_avail), 32'd0);
    chk("t1_ack", 32'(ack_o_s), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // T2: single descriptor, also shows wcnt restarted after the reset
    wr(16'h1111); wr(16'h2222); wr(16'h3333);
    chk("t2_free_3w", 32'(free_bd), 32'd8);
    chk("t2_avail_3w", 32'(bd_avail), 32'd0);
    wr(16'h4444);
    chk("t2_free_4w", 32'(free_bd), 32'd7);
    chk("t2_avail_4w", 32'(bd_avail), 32'd1);
    rd("t2_r0", 16'h1111);
    chk("t2_avail_r0", 32'(bd_avail), 32'd0);
    rd("t2_r1", 16'h2222);
    rd("t2_r2", 16'h3333);
    rd("t2_r3", 16'h4444);
    tick();
    chk("t2_ack_drop", 32'(ack_o_s), 32'd0);
    chk("t2_dat_hold", 32'(dat_out_s), 32'h4444);
    chk("t2_free_pre", 32'(free_bd), 32'd7);
    cmp();
    chk("t2_free_cmp", 32'(free_bd), 32'd8);

    // T3: fill all slots, overflow on the ninth
    for (int d = 0; d < 8; d++) wr_desc(16'h0C00 + 16'(d * 16));
    chk("t3_free_full", 32'(free_bd), 32'd0);
    chk("t3_avail_full", 32'(bd_avail), 32'd1);
    wr(16'hDEAD);
    chk("t3_ovf", 32'(overflow_o), 32'd1);
    chk("t3_free_ovf", 32'(free_bd), 32'd0);
    tick();
    chk("t3_ovf_drop", 32'(overflow_o), 32'd0);
    rd_desc("t3_d0", 16'h0C00);
    cmp();
    chk("t3_free_cmp", 32'(free_bd), 32'd1);
    for (int d = 1; d < 8; d++) begin
      rd_desc("t3_dn", 16'h0C00 + 16'(d * 16));
      cmp();
    end
    chk("t3_free_drain", 32'(free_bd), 32'd8);
    chk("t3_avail_drain", 32'(bd_avail), 32'd0);

    // T4: 12 descriptors, writer two ahead of reader, pointers wrap
    wr_desc(16'h0000);
    wr_desc(16'h1000);
    fr = 6;
    for (int d = 0; d < 12; d++) begin
      if (d + 2 < 12) begin
        wr_desc(16'((d + 2) * 16'h1000));
        fr--;
      end
      rd_desc((d == 9) ? "t4_d9" : "t4_dn", 16'(d * 16'h1000));
      cmp();
      fr++;
      chk("t4_free", 32'(free_bd), 32'(fr));
    end
    chk("t4_avail_end", 32'(bd_avail), 32'd0);

    // T5: coincident commit and release, empty read, idle release
    wr_desc(16'h5A00);
    rd_desc("t5_a", 16'h5A00);
    chk("t5_free_a", 32'(free_bd), 32'd7);
    wr(16'h5B00); wr(16'h5B01); wr(16'h5B02);
    we_m = 1'b1; dat_in_m = 16'h5B03; a_cmp = 1'b1;
    tick();
    we_m = 1'b0; a_cmp = 1'b0;
    chk("t5_free_coinc", 32'(free_bd), 32'd7);
    chk("t5_avail_coinc", 32'(bd_avail), 32'd1);
    rd_desc("t5_b", 16'h5B00);
    cmp();
    chk("t5_free_b", 32'(free_bd), 32'd8);
    re_s = 1'b1;
    tick();
    re_s = 1'b0;
    chk("t5_noack", 32'(ack_o_s), 32'd0);
    cmp();
    chk("t5_idle_cmp", 32'(free_bd), 32'd8);
    wr_desc(16'h5C00);
    rd_desc("t5_c", 16'h5C00);
    cmp();
    chk("t5_free_c", 32'(free_bd), 32'd8);

    // T6: flush with three descriptors stored and one mid-read
    wr_desc(16'h6000); wr_desc(16'h6100); wr_desc(16'h6200);
    rd("t6_pre0", 16'h6000);
    rd("t6_pre1", 16'h6001);
    chk("t6_free_pre", 32'(free_bd), 32'd5);
    clr_i = 1'b1; re_s = 1'b1; we_m = 1'b1; dat_in_m = 16'hBAD0; a_cmp = 1'b1;
    tick();
    clr_i = 1'b0; re_s = 1'b0; we_m = 1'b0; a_cmp = 1'b0;
    chk("t6_free", 32'(free_bd), 32'd8);
    chk("t6_avail", 32'(bd_avail), 32'd0);
    chk("t6_ack", 32'(ack_o_s), 32'd0);
    chk("t6_dat", 32'(dat_out_s), 32'd0);
    re_s = 1'b1;
    tick();
    re_s = 1'b0;
    chk("t6_stale_ack", 32'(ack_o_s), 32'd0);
    wr_desc(16'h6F00);
    chk("t6_free_new", 32'(free_bd), 32'd7);
    rd_desc("t6_new", 16'h6F00);
    cmp();
    chk("t6_free_end", 32'(free_bd), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
